// File: rtl/sid_bus_master_pkg.sv
// Shared types for the SID bus master.
//   bus_op_e   : host command opcodes (write, read, reset, delay)
//   bus_cmd_t  : one buffered host command {op, addr, data}
//   bus_i_t    : SID register bus as seen by the SID core {addr, data, we, oe, res}
//   bm_state_e : bus master sequencing states
package sid_bus_master_pkg;

    typedef enum logic [1:0] {
        OpWrite = 2'd0,
        OpRead  = 2'd1,
        OpReset = 2'd2,
        OpDelay = 2'd3
    } bus_op_e;

    typedef struct packed {
        bus_op_e     op;
        logic [4:0]  addr;
        logic [7:0]  data;
    } bus_cmd_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        we;
        logic        oe;
        logic        res;
    } bus_i_t;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StReset,
        StDelay
    } bm_state_e;

    localparam int unsigned BusWidth = $bits(bus_i_t);

endpackage

// File: rtl/sid_cmd_fifo.sv
// Synchronous command FIFO for the SID bus master.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push/wdata : write a command; ignored while full
//   pop/rdata  : rdata is the head entry; pop removes it; ignored while empty
//   full/empty : occupancy flags
//   count      : number of stored entries
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module sid_cmd_fifo
    import sid_bus_master_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  bus_cmd_t                 wdata,
    input  logic                     pop,
    output bus_cmd_t                 rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    bus_cmd_t          mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full    = (count_q == (PtrW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count/pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/sid_bus_master.sv
// SID register bus initiator.
//   clk, rst_n          : clock, asynchronous active-low reset
//   phi2_tick           : one-clk strobe at the start of each SID cycle
//   cmd_valid/cmd_ready : host command handshake; cmd_op/cmd_addr/cmd_data carry the command
//   rsp_valid/rsp_ready : read response handshake; rsp_data carries the read byte
//   bus_data_i          : SID read-data bus
//   bus_o               : packed {addr[15:0], data, we, oe, res} to the SID core
//   busy                : commands pending, one in progress, or a response unconsumed
// Each command occupies the bus from one phi2 tick to a later one; the tick that ends a
// command also dispatches the next eligible one, giving one access per SID cycle.
module sid_bus_master
    import sid_bus_master_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RES_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        phi2_tick,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    input  logic [7:0]  bus_data_i,
    output logic [26:0] bus_o,
    output logic        busy
);

    localparam int unsigned ResW = $clog2(RES_CYCLES + 1);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    bm_state_e         state_q, state_d;
    bus_i_t            bus_q, bus_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [7:0]        rsp_data_q, rsp_data_d;
    logic [7:0]        dly_q, dly_d;
    logic [ResW-1:0]   res_q, res_d;

    bus_cmd_t          new_cmd;
    bus_cmd_t          head;
    logic              fifo_full, fifo_empty;
    logic [CntW-1:0]   fifo_count;
    logic              push, pop;
    logic              cmd_done, read_done;

    // Held low during reset so the host cannot push into a FIFO being cleared.
    assign cmd_ready = rst_n && !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign new_cmd   = '{op: bus_op_e'(cmd_op), addr: cmd_addr, data: cmd_data};

    sid_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (new_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        bus_d       = bus_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        dly_d       = dly_q;
        res_d       = res_q;
        pop         = 1'b0;
        cmd_done    = 1'b0;
        read_done   = 1'b0;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        if (phi2_tick) begin
            unique case (state_q)
                StIdle: begin
                    cmd_done = 1'b1;
                end
                StAccess: begin
                    cmd_done = 1'b1;
                    if (bus_q.oe) begin
                        read_done   = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = bus_data_i;
                    end
                end
                StReset: begin
                    if (res_q <= ResW'(1)) begin
                        cmd_done = 1'b1;
                    end else begin
                        res_d = res_q - ResW'(1);
                    end
                end
                StDelay: begin
                    if (dly_q <= 8'd1) begin
                        cmd_done = 1'b1;
                    end else begin
                        dly_d = dly_q - 8'd1;
                    end
                end
            endcase

            if (cmd_done) begin
                state_d   = StIdle;
                bus_d.we  = 1'b0;
                bus_d.oe  = 1'b0;
                bus_d.res = 1'b0;
                // A read completing on this very tick also blocks the next read.
                if (!fifo_empty &&
                    !(head.op == OpRead && (rsp_valid_q || read_done))) begin
                    pop = 1'b1;
                    unique case (head.op)
                        OpWrite: begin
                            state_d    = StAccess;
                            bus_d.addr = {11'd0, head.addr};
                            bus_d.data = head.data;
                            bus_d.we   = 1'b1;
                        end
                        OpRead: begin
                            state_d    = StAccess;
                            bus_d.addr = {11'd0, head.addr};
                            bus_d.data = 8'd0;
                            bus_d.oe   = 1'b1;
                        end
                        OpReset: begin
                            state_d   = StReset;
                            bus_d.res = 1'b1;
                            res_d     = ResW'(RES_CYCLES);
                        end
                        OpDelay: begin
                            dly_d   = head.data;
                            // A zero-length delay is finished as soon as it is taken.
                            state_d = (head.data == 8'd0) ? StIdle : StDelay;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bus_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
            dly_q       <= 8'd0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            bus_q       <= bus_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            dly_q       <= dly_d;
            res_q       <= res_d;
        end
    end

    assign bus_o     = bus_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (fifo_count != '0) || (state_q != StIdle) || rsp_valid_q;

endmodule

// File: tb/tb_sid_bus_master.sv
module tb_sid_bus_master;

    localparam int FIFO_DEPTH = 4;
    localparam int RES_CYCLES = 10;
    localparam int TICK       = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        phi2_tick = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [4:0]  cmd_addr = 5'd0;
    logic [7:0]  cmd_data = 8'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic [7:0]  bus_data_i = 8'd0;
    logic [26:0] bus_o;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    sid_bus_master #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .RES_CYCLES (RES_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .phi2_tick  (phi2_tick),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .bus_data_i (bus_data_i),
        .bus_o      (bus_o),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // phi2 strobe: one clk high every TICK clks
    int tick_cnt = 0;
    always @(negedge clk) begin
        tick_cnt  = (tick_cnt == TICK - 1) ? 0 : tick_cnt + 1;
        phi2_tick = (tick_cnt == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each command is a job lasting a number of SID ticks; a queue holds pending jobs.
    typedef struct {
        int op;
        int addr;
        int data;
    } mcmd_t;

    mcmd_t       mq[$];
    int          m_op  = -1;   // active job op, -1 = none
    int          m_rem = 0;    // ticks until the active job ends
    logic [15:0] m_addr = '0;
    logic [7:0]  m_data = '0;
    logic        m_we = 0, m_oe = 0, m_res = 0, m_rv = 0;
    logic [7:0]  m_rd = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_op = -1; m_rem = 0;
            m_addr = '0; m_data = '0;
            m_we = 0; m_oe = 0; m_res = 0; m_rv = 0; m_rd = '0;
        end else begin
            bit    old_rv, do_push, rd_done;
            mcmd_t h, nc;
            old_rv  = m_rv;
            do_push = cmd_valid && (mq.size() < FIFO_DEPTH);
            nc.op   = int'(cmd_op);
            nc.addr = int'(cmd_addr);
            nc.data = int'(cmd_data);
            rd_done = 0;
            if (old_rv && rsp_ready) m_rv = 0;
            if (phi2_tick) begin
                if (m_op != -1) begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0 && m_op == 1) begin
                        m_rv = 1; m_rd = bus_data_i; rd_done = 1;
                    end
                end
                if (m_op == -1 || m_rem == 0) begin
                    m_op = -1; m_we = 0; m_oe = 0; m_res = 0;
                    if (mq.size() > 0 && !(mq[0].op == 1 && (old_rv || rd_done))) begin
                        h = mq.pop_front();
                        case (h.op)
                            0: begin
                                m_op = 0; m_rem = 1; m_we = 1;
                                m_addr = 16'(h.addr); m_data = 8'(h.data);
                            end
                            1: begin
                                m_op = 1; m_rem = 1; m_oe = 1;
                                m_addr = 16'(h.addr); m_data = 8'd0;
                            end
                            2: begin
                                m_op = 2; m_rem = RES_CYCLES; m_res = 1;
                            end
                            default: begin
                                if (h.data != 0) begin m_op = 3; m_rem = h.data; end
                            end
                        endcase
                    end
                end
            end
            if (do_push) mq.push_back(nc);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("bus_o", 32'(bus_o), 32'({m_addr, m_data, m_we, m_oe, m_res}));
        check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        check("rsp_data", 32'(rsp_data), 32'(m_rd));
        check("cmd_ready", 32'(cmd_ready), 32'(rst_n && (mq.size() < FIFO_DEPTH)));
        check("busy", 32'(busy), 32'((mq.size() != 0) || (m_op != -1) || m_rv));
    end

    // Run-length monitor on the bus strobes.
    int we_run = 0, we_last = 0, res_run = 0, res_last = 0, idle_run = 0, idle_last = 0;
    always @(negedge clk) begin
        if (bus_o[2]) we_run++;
        else if (we_run != 0) begin we_last = we_run; we_run = 0; end
        if (bus_o[0]) res_run++;
        else if (res_run != 0) begin res_last = res_run; res_run = 0; end
        if (bus_o[2:0] == 3'b000) idle_run++;
        else if (idle_run != 0) begin idle_last = idle_run; idle_run = 0; end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus_o[2];
            1:       return bus_o[1];
            2:       return bus_o[0];
            3:       return rsp_valid;
            default: return busy;
        endcase
    endfunction

    task automatic wait_bit(input int sel, input logic val, input int limit, input string name);
        int n = 0;
        while (sig(sel) !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (sig(sel) !== val) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timed out after %0d clk, signal is %b, required %b",
                     name, n, sig(sel), val);
        end
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [4:0] a, input logic [7:0] d,
                            input int limit);
        logic rdy;
        int   n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        rdy = cmd_ready;
        while (!rdy && n < limit) begin
            @(negedge clk);
            rdy = cmd_ready;
            n++;
        end
        if (!rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL push op%0d: cmd_ready stayed 0 for %0d clk, required 1", op, n);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int n;
        #1 rst_n = 1'b0;
        #3;
        check("reset bus_o", 32'(bus_o), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_data", 32'(rsp_data), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset cmd_ready", 32'(cmd_ready), 32'd0);
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);

        // Single write
        push_cmd(2'd0, 5'h18, 8'h0F, 10);
        wait_bit(0, 1'b1, 100, "write we rise");
        check("write bus_o", 32'(bus_o), 32'({16'h0018, 8'h0F, 3'b100}));
        wait_bit(0, 1'b0, 100, "write we fall");
        #1;
        check("write we length", 32'(we_last), 32'd20);
        check("write busy after", 32'(busy), 32'd0);

        // Single read with held response
        bus_data_i = 8'hA5;
        push_cmd(2'd1, 5'h1B, 8'h00, 10);
        wait_bit(1, 1'b1, 100, "read oe rise");
        check("read bus_o", 32'(bus_o), 32'({16'h001B, 8'h00, 3'b010}));
        wait_bit(1, 1'b0, 100, "read oe fall");
        check("read rsp_valid", 32'(rsp_valid), 32'd1);
        check("read rsp_data", 32'(rsp_data), 32'hA5);
        repeat (50) @(negedge clk);
        check("read rsp held", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("read rsp cleared", 32'(rsp_valid), 32'd0);

        // Back-to-back writes filling the FIFO
        wait_bit(4, 1'b0, 200, "idle before b2b");
        n = 0;
        do begin @(posedge clk); n++; end while (!phi2_tick && n < 40);
        @(negedge clk);
        for (int i = 0; i < 4; i++) push_cmd(2'd0, 5'(i), 8'(8'h10 + i), 10);
        check("b2b full ready", 32'(cmd_ready), 32'd0);
        push_cmd(2'd0, 5'h04, 8'h14, 60);
        wait_bit(0, 1'b0, 200, "b2b we fall");
        #1;
        check("b2b we continuous", 32'(we_last), 32'd100);

        // Reset, delay 3, write, delay 0, write
        wait_bit(4, 1'b0, 200, "idle before res");
        push_cmd(2'd2, 5'h00, 8'h00, 10);
        push_cmd(2'd3, 5'h00, 8'h03, 10);
        push_cmd(2'd0, 5'h04, 8'h55, 10);
        push_cmd(2'd3, 5'h00, 8'h00, 10);
        push_cmd(2'd0, 5'h05, 8'h66, 300);
        wait_bit(2, 1'b1, 100, "res rise");
        wait_bit(2, 1'b0, 400, "res fall");
        #1;
        check("res length", 32'(res_last), 32'd200);
        wait_bit(0, 1'b1, 200, "post-delay we rise");
        #1;
        check("delay3 idle gap", 32'(idle_last), 32'd60);
        check("delay3 write bus_o", 32'(bus_o), 32'({16'h0004, 8'h55, 3'b100}));
        wait_bit(0, 1'b0, 100, "we fall after 0x04");
        wait_bit(0, 1'b1, 100, "we rise for 0x05");
        #1;
        check("delay0 idle gap", 32'(idle_last), 32'd20);
        check("delay0 write bus_o", 32'(bus_o), 32'({16'h0005, 8'h66, 3'b100}));

        // Read stall while a response is pending
        wait_bit(4, 1'b0, 200, "idle before stall");
        bus_data_i = 8'h3C;
        push_cmd(2'd1, 5'h01, 8'h00, 10);
        push_cmd(2'd1, 5'h02, 8'h00, 10);
        wait_bit(3, 1'b1, 100, "stall rsp1");
        #1;
        check("stall rsp1 data", 32'(rsp_data), 32'h3C);
        repeat (60) @(negedge clk);
        check("stall oe low", 32'(bus_o[1]), 32'd0);
        check("stall addr held", 32'(bus_o[26:11]), 32'h1);
        bus_data_i = 8'h7E;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        wait_bit(1, 1'b1, 100, "stall read2 oe");
        check("stall read2 addr", 32'(bus_o[26:11]), 32'h2);
        wait_bit(3, 1'b1, 100, "stall rsp2");
        #1;
        check("stall rsp2 data", 32'(rsp_data), 32'h7E);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Asynchronous reset in the middle of a RESET command
        wait_bit(4, 1'b0, 200, "idle before abort");
        push_cmd(2'd2, 5'h00, 8'h00, 10);
        push_cmd(2'd0, 5'h06, 8'h77, 10);
        push_cmd(2'd0, 5'h07, 8'h88, 10);
        wait_bit(2, 1'b1, 100, "abort res rise");
        repeat (30) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort bus_o", 32'(bus_o), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort cmd_ready", 32'(cmd_ready), 32'd0);
        #20 rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("post-abort busy", 32'(busy), 32'd0);
        check("post-abort bus_o", 32'(bus_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
